// File: rtl/dataflow_seq.sv
// Sequences NUM_STG ap_ctrl_chain stages for n_iter invocations each per run.
// Optional stall watchdog enabled by defining DFSEQ_WATCHDOG_EN.
module dataflow_seq #(
    parameter int unsigned NUM_STG = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               ap_start,
    input  logic               ap_continue,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    input  logic [CNT_W-1:0]   n_iter,
    output logic [NUM_STG-1:0] stg_start,
    output logic [NUM_STG-1:0] stg_continue,
    input  logic [NUM_STG-1:0] stg_ready,
    input  logic [NUM_STG-1:0] stg_done,
    output logic [CNT_W-1:0]   iter_cnt,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] start_cnt [NUM_STG];
    logic [CNT_W-1:0] done_cnt  [NUM_STG];
    logic             all_done;
    logic             accept;
    logic             wd_trip;

    assign accept       = (state == S_IDLE) && ap_start;
    assign ap_ready     = accept;
    assign ap_idle      = (state == S_IDLE) && !ap_start;
    assign ap_done      = (state == S_DONE);
    assign stg_continue = {NUM_STG{state == S_RUN}};
    assign iter_cnt     = done_cnt[NUM_STG-1];

    always_comb begin
        all_done = 1'b1;
        for (int unsigned k = 0; k < NUM_STG; k++) begin
            if (done_cnt[k] != n_lat) all_done = 1'b0;
        end
    end

    // One outstanding invocation per stage: issue only when every start has completed.
    always_comb begin
        stg_start = '0;
        for (int unsigned k = 0; k < NUM_STG; k++) begin
            stg_start[k] = (state == S_RUN) && (start_cnt[k] < n_lat)
                           && (start_cnt[k] == done_cnt[k]);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            n_lat <= '0;
            for (int unsigned k = 0; k < NUM_STG; k++) begin
                start_cnt[k] <= '0;
                done_cnt[k]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        n_lat <= n_iter;
                        for (int unsigned k = 0; k < NUM_STG; k++) begin
                            start_cnt[k] <= '0;
                            done_cnt[k]  <= '0;
                        end
                        state <= (n_iter != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    for (int unsigned k = 0; k < NUM_STG; k++) begin
                        if (stg_start[k] && stg_ready[k]) start_cnt[k] <= start_cnt[k] + 1'b1;
                        if (stg_done[k]) done_cnt[k] <= done_cnt[k] + 1'b1;
                    end
                    if (all_done || wd_trip) state <= S_DONE;
                end
                S_DONE: begin
                    if (ap_continue) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DFSEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign wd_trip = (state == S_RUN) && (wd_cnt == '1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else if (state == S_RUN) begin
            if ((|stg_done) || (|stg_ready)) begin
                wd_cnt <= '0;
            end else if (wd_trip) begin
                err <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_dataflow_seq.sv
// Bench for dataflow_seq: randomized stage responders checked against a
// run-level model of start/completion counts per stage.
module tb_dataflow_seq;

    localparam int NS = 3;
    localparam int CW = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_continue;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [CW-1:0] n_iter;
    logic [NS-1:0] stg_start;
    logic [NS-1:0] stg_continue;
    logic [NS-1:0] stg_ready;
    logic [NS-1:0] stg_done;
    logic [CW-1:0] iter_cnt;
    logic          err;

    dataflow_seq #(.NUM_STG(NS), .CNT_W(CW)) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .ap_start     (ap_start),
        .ap_continue  (ap_continue),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .n_iter       (n_iter),
        .stg_start    (stg_start),
        .stg_continue (stg_continue),
        .stg_ready    (stg_ready),
        .stg_done     (stg_done),
        .iter_cnt     (iter_cnt),
        .err          (err)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: run phase (0 idle, 1 running, 2 done) and handshake tallies.
    int phase;
    int n_model;
    int starts [NS];
    int dones  [NS];
    // Stage responders.
    int busy [NS];
    int lat_left [NS];
    int hold [NS];
    int lat_min, lat_max, hold_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NS; k++) begin
            starts[k] = 0; dones[k] = 0;
            busy[k] = 0; lat_left[k] = 0; hold[k] = 0;
        end
        stg_ready = '0;
        stg_done  = '0;
    endtask

    // Called at a falling edge after inputs are set; returns at the next falling edge.
    task automatic step();
        logic [31:0] exp_start;
        bit          fin;
        int          rdy, dn, l;
        #1;
        check("ap_ready", {31'b0, ap_ready}, {31'b0, (phase == 0) && ap_start});
        check("ap_idle",  {31'b0, ap_idle},  {31'b0, (phase == 0) && !ap_start});
        @(posedge ap_clk);
        if (phase == 0) begin
            if (ap_start) begin
                n_model = int'(n_iter);
                for (int k = 0; k < NS; k++) begin starts[k] = 0; dones[k] = 0; end
                phase = (n_model != 0) ? 1 : 2;
            end
        end else if (phase == 1) begin
            fin = 1'b1;
            for (int k = 0; k < NS; k++) if (dones[k] != n_model) fin = 1'b0;
            for (int k = 0; k < NS; k++) begin
                starts[k] += int'(stg_ready[k]);
                dones[k]  += int'(stg_done[k]);
            end
            if (fin) phase = 2;
        end else if (ap_continue) begin
            phase = 0;
        end
        @(negedge ap_clk);
        exp_start = '0;
        for (int k = 0; k < NS; k++)
            exp_start[k] = (phase == 1) && (starts[k] < n_model) && (starts[k] == dones[k]);
        check("stg_start",    {29'b0, stg_start},    exp_start);
        check("stg_continue", {29'b0, stg_continue}, (phase == 1) ? 32'h7 : 32'h0);
        check("ap_done",      {31'b0, ap_done},      {31'b0, phase == 2});
        check("iter_cnt",     {24'b0, iter_cnt},     dones[NS-1]);
        check("err",          {31'b0, err},          32'h0);
        for (int k = 0; k < NS; k++) begin
            rdy = 0; dn = 0;
            if (busy[k] != 0) begin
                if (lat_left[k] == 0) begin dn = 1; busy[k] = 0; end
                else lat_left[k]--;
            end else if (stg_start[k]) begin
                if (hold[k] > 0) hold[k]--;
                else begin
                    rdy = 1;
                    hold[k] = $urandom_range(hold_max, 0);
                    l = $urandom_range(lat_max, lat_min);
                    if (l == 0) dn = 1;
                    else begin busy[k] = 1; lat_left[k] = l - 1; end
                end
            end
            stg_ready[k] = rdy[0];
            stg_done[k]  = dn[0];
        end
    endtask

    task automatic run(input int n, input int budget);
        int cnt;
        n_iter = CW'(n);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        cnt = 0;
        while (phase != 2 && cnt < budget) begin
            if (phase == 1) begin
                ap_start = 1'($urandom_range(1, 0));
                n_iter   = CW'($urandom_range(255, 0));
            end
            step();
            cnt++;
        end
        ap_start = 1'b0;
        check("run_done", {31'b0, ap_done}, 32'h1);
        for (int k = 0; k < NS; k++) begin
            check($sformatf("starts%0d", k), starts[k], n);
            check($sformatf("dones%0d", k), dones[k], n);
        end
        check("iter_final", {24'b0, iter_cnt}, n);
    endtask

    task automatic finish_run(input int wait_cyc);
        ap_continue = 1'b0;
        repeat (wait_cyc) step();
        check("done_held", {31'b0, ap_done}, 32'h1);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        step();
        check("idle_after", {31'b0, ap_idle}, 32'h1);
    endtask

    initial begin
        int cnt;
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; n_iter = '0;
        phase = 0; n_model = 0;
        lat_min = 0; lat_max = 0; hold_max = 0;
        clear_model();
        #1;
        check("rst_done",  {31'b0, ap_done},      32'h0);
        check("rst_ready", {31'b0, ap_ready},     32'h0);
        check("rst_idle",  {31'b0, ap_idle},      32'h1);
        check("rst_start", {29'b0, stg_start},    32'h0);
        check("rst_cont",  {29'b0, stg_continue}, 32'h0);
        check("rst_iter",  {24'b0, iter_cnt},     32'h0);
        check("rst_err",   {31'b0, err},          32'h0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // n=3, ready in the issuing cycle, done four cycles after ready
        lat_min = 4; lat_max = 4; hold_max = 0;
        run(3, 100);
        finish_run(2);

        // n=0: straight to DONE with no stage starts
        run(0, 10);
        finish_run(0);

        // DONE holds without continue
        lat_min = 1; lat_max = 2;
        run(2, 60);
        finish_run(10);

        // Stage 2 withholds ready for 20 cycles
        lat_min = 0; lat_max = 3; hold_max = 0;
        hold[2] = 20;
        run(4, 200);
        finish_run(1);

        // Randomized runs, including same-cycle ready+done (latency 0)
        for (int r = 0; r < 6; r++) begin
            lat_min  = $urandom_range(1, 0);
            lat_max  = lat_min + $urandom_range(5, 0);
            hold_max = $urandom_range(3, 0);
            cnt = $urandom_range(12, 1);
            run(cnt, cnt * (lat_max + hold_max + 4) + 50);
            finish_run($urandom_range(3, 0));
        end

        // Full-scale count must complete without wrap
        lat_min = 0; lat_max = 1; hold_max = 0;
        run(255, 255 * 5 + 50);
        finish_run(1);

        // Reset after two of five iterations of the last stage
        lat_min = 2; lat_max = 3; hold_max = 0;
        n_iter = CW'(5);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        cnt = 0;
        while (dones[NS-1] < 2 && cnt < 200) begin step(); cnt++; end
        check("mid_progress", dones[NS-1], 2);
        #2 ap_rst_n = 1'b0;
        #1;
        check("arst_done",  {31'b0, ap_done},      32'h0);
        check("arst_ready", {31'b0, ap_ready},     32'h0);
        check("arst_start", {29'b0, stg_start},    32'h0);
        check("arst_cont",  {29'b0, stg_continue}, 32'h0);
        check("arst_iter",  {24'b0, iter_cnt},     32'h0);
        check("arst_err",   {31'b0, err},          32'h0);
        phase = 0;
        clear_model();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        step();
        run(5, 150);
        finish_run(1);

`ifdef DFSEQ_WATCHDOG_EN
        // Stages never respond: watchdog must abort the run with err set
        stg_ready = '0;
        stg_done  = '0;
        n_iter = CW'(1);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        cnt = 0;
        while (!ap_done && cnt < 70000) begin @(posedge ap_clk); #1; cnt++; end
        check("wd_done", {31'b0, ap_done}, 32'h1);
        check("wd_err",  {31'b0, err},     32'h1);
        check("wd_time", {31'b0, (cnt >= 65530) && (cnt <= 65540)}, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
